// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches one ROM word per cycle and
// buffers {pc, instruction} in a DEPTH-entry FIFO so fetch runs ahead of IF/ID.
module fetch_prefetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               R,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               LE,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_next_pc,
    output logic [CNT_W-1:0]   count,
    output logic               full
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];
    logic               push, pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign rom_addr  = pc_q;
    assign pop       = LE & out_valid;
    assign push      = ~branch & (~full | pop);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        pc_d    = pc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (branch) begin
            // Redirect wins over push/pop: the queue is flushed outright.
            pc_d    = branch_target;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + STEP;
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (R) begin
            pc_q    <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wptr_q] <= rom_data;
            mem_pc_q[wptr_q]    <= pc_q;
        end
    end

    assign out_instr   = out_valid ? mem_instr_q[rptr_q] : '0;
    assign out_pc      = out_valid ? mem_pc_q[rptr_q] : '0;
    assign out_next_pc = out_valid ? mem_pc_q[rptr_q] + STEP : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        LE = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [7:0]  out_next_pc;
    logic [2:0]  count;
    logic        full;

    logic [31:0] rom_mem [256];
    assign rom_data = rom_mem[rom_addr];

    fetch_prefetch_queue dut (
        .clk          (clk),
        .R            (R),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .LE           (LE),
        .branch       (branch),
        .branch_target(branch_target),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_next_pc  (out_next_pc),
        .count        (count),
        .full         (full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of fetched entries plus the fetch PC.
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } ent_t;
    ent_t       m_q[$];
    logic [7:0] m_pc = '0;

    task automatic model_step(input logic r, le, br, input logic [7:0] tgt);
        bit was_full;
        bit do_pop;
        ent_t e;
        if (r) begin
            m_pc = '0;
            m_q.delete();
        end else if (br) begin
            m_pc = tgt;
            m_q.delete();
        end else begin
            was_full = (m_q.size() == DEPTH);
            do_pop   = le && (m_q.size() > 0);
            if (do_pop) void'(m_q.pop_front());
            if (!was_full || do_pop) begin
                e.pc    = m_pc;
                e.instr = rom_mem[m_pc];
                m_q.push_back(e);
                m_pc = m_pc + 8'd4;
            end
        end
    endtask

    // Expected {valid, instr, pc, next_pc, count, full, rom_addr}.
    function automatic logic [60:0] exp_vec();
        logic        v;
        logic [31:0] ins;
        logic [7:0]  p, np;
        v   = (m_q.size() > 0);
        ins = v ? m_q[0].instr : 32'h0;
        p   = v ? m_q[0].pc : 8'h0;
        np  = v ? 8'(m_q[0].pc + 8'd4) : 8'h0;
        return {v, ins, p, np, 3'(m_q.size()), (m_q.size() == DEPTH), m_pc};
    endfunction

    logic [60:0] dut_vec;
    assign dut_vec = {out_valid, out_instr, out_pc, out_next_pc, count, full, rom_addr};

    // Occupancy must never leave 0..DEPTH.
    always @(negedge clk) begin
        if (!R) assert (count <= 3'(DEPTH))
            else $error("count out of range: %0d", count);
    end

    // Drive one cycle from just after a falling edge; returns after the next falling edge.
    task automatic tick(input logic r, le, br, input logic [7:0] tgt);
        R = r; LE = le; branch = br; branch_target = tgt;
        @(posedge clk);
        model_step(r, le, br, tgt);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 8'h00);
        tick(1, 1, 1, 8'h40);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_vec got=%h want=%h", dut_vec, exp_vec());
        end
        total++;
        if ({out_valid, count, full, rom_addr, out_pc} !== 20'h0) begin
            bad++; $display("FAIL reset_zero valid=%b count=%0d full=%b addr=%h pc=%h want all 0",
                            out_valid, count, full, rom_addr, out_pc);
        end
    endtask

    task automatic test_fill();
        tick(1, 0, 0, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            tick(0, 0, 0, 8'h00);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL fill_vec[%0d] got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (rom_addr !== 8'd16 || count !== 3'd4 || full !== 1'b1) begin
            bad++; $display("FAIL fill_full addr=%h count=%0d full=%b want 10/4/1", rom_addr, count, full);
        end
        total++;
        if (out_pc !== 8'h00 || out_instr !== 32'h100 || out_next_pc !== 8'h04) begin
            bad++; $display("FAIL fill_head pc=%h instr=%h next=%h want 00/00000100/04",
                            out_pc, out_instr, out_next_pc);
        end
    endtask

    task automatic test_full_pushpop();
        tick(0, 1, 0, 8'h00);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL fullpp_vec got=%h want=%h", dut_vec, exp_vec());
        end
        total++;
        if (count !== 3'd4 || out_pc !== 8'h04 || rom_addr !== 8'd20) begin
            bad++; $display("FAIL fullpp count=%0d pc=%h addr=%h want 4/04/14", count, out_pc, rom_addr);
        end
        // Drain: the tail fetched during the push/pop must be pc=16.
        for (int i = 0; i < 4; i++) tick(0, 0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 8'h00);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL fullpp_drain[%0d] got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_steady();
        tick(1, 1, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            tick(0, 1, 0, 8'h00);
            total++;
            if (out_valid !== 1'b1 || count !== 3'd1 || out_pc !== 8'(4 * k)) begin
                bad++; $display("FAIL steady[%0d] valid=%b count=%0d pc=%h want 1/1/%h",
                                k, out_valid, count, out_pc, 8'(4 * k));
            end
        end
    endtask

    task automatic test_branch();
        tick(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00);
        total++;
        if (count !== 3'd3) begin
            bad++; $display("FAIL branch_pre count=%0d want 3", count);
        end
        tick(0, 1, 1, 8'h40);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || rom_addr !== 8'h40) begin
            bad++; $display("FAIL branch_flush count=%0d valid=%b addr=%h want 0/0/40", count, out_valid, rom_addr);
        end
        tick(0, 1, 0, 8'h00);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_next_pc !== 8'h44) begin
            bad++; $display("FAIL branch_head valid=%b pc=%h next=%h want 1/40/44", out_valid, out_pc, out_next_pc);
        end
        for (int i = 1; i < 4; i++) begin
            tick(0, 1, 0, 8'h00);
            total++;
            if (out_pc !== 8'(8'h40 + 4 * i)) begin
                bad++; $display("FAIL branch_seq[%0d] pc=%h want %h", i, out_pc, 8'(8'h40 + 4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want [4];
        want[0] = 8'hF8; want[1] = 8'hFC; want[2] = 8'h00; want[3] = 8'h04;
        tick(0, 1, 1, 8'hF8);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 8'h00);
            total++;
            if (out_pc !== want[i] || out_next_pc !== 8'(want[i] + 8'd4)) begin
                bad++; $display("FAIL wrap[%0d] pc=%h next=%h want %h/%h",
                                i, out_pc, out_next_pc, want[i], 8'(want[i] + 8'd4));
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 8'h00);
        tick(0, 0, 0, 8'h00);
        tick(0, 0, 0, 8'h00);
        total++;
        if (count !== 3'd2) begin
            bad++; $display("FAIL rmid_pre count=%0d want 2", count);
        end
        tick(1, 1, 1, 8'h80);
        total++;
        if (dut_vec !== 61'h0) begin
            bad++; $display("FAIL rmid_zero got=%h want 0", dut_vec);
        end
    endtask

    task automatic test_random();
        logic r, le, br;
        logic [7:0] tgt;
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        tick(1, 0, 0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            br  = ($urandom_range(0, 19) == 0);
            le  = ($urandom_range(0, 9) < 6);
            tgt = 8'($urandom);
            tick(r, le, br, tgt);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random[%0d] got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'h100 + i;
        test_reset();
        test_fill();
        test_full_pushpop();
        test_steady();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single PC register and PC adder feeding IF/ID. It owns the PC and fetches one word per cycle from the combinational instruction ROM. Fetched {pc, next_pc, instruction} entries go into a DEPTH-entry FIFO, so fetch keeps running while the IF/ID register is stalled by the forwarding unit. A taken branch flushes the queue and redirects the PC.

Parameters:
ADDR_W, 8, PC and ROM address width; the PC wraps modulo 2^ADDR_W.
INSTR_W, 32, instruction word width.
DEPTH, 4, queue entries; must be at least 2 (any integer, not limited to powers of 2).
PC_STEP, 4, PC increment per fetched instruction.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
R  in  1  synchronous active-high reset.
rom_addr  out  ADDR_W  fetch address; always equals the internal PC.
rom_data  in  INSTR_W  ROM word at rom_addr, valid in the same cycle.
LE  in  1  consumer (IF/ID) accepts the head entry this cycle; 0 means stall.
branch  in  1  taken branch or branch-with-link from the condition handler.
branch_target  in  ADDR_W  redirect address from the target-address adder.
out_valid  out  1  queue is non-empty.
out_instr  out  INSTR_W  head instruction; all zeros when empty.
out_pc  out  ADDR_W  address of the head instruction; zero when empty.
out_next_pc  out  ADDR_W  out_pc + PC_STEP (mod 2^ADDR_W); zero when empty.
count  out  CNT_W  number of valid entries, 0..DEPTH.
full  out  1  count == DEPTH.

Behaviour:
- Reset (R=1 at a clk edge): pc=0, read/write pointers=0, count=0. Therefore out_valid=0, out_instr/out_pc/out_next_pc=0, full=0. Reset overrides branch and LE. Reset mid-operation discards all entries.
- pop = LE & out_valid. LE while empty has no effect.
- push = !branch & (!full | pop). A pushed entry is {pc, pc+PC_STEP, rom_data}, written at wptr, and pc <= pc+PC_STEP.
- When full without a pop, there is no push and pc holds, so the same address is refetched next cycle. No word is lost or duplicated.
- Push and pop in the same cycle leave count unchanged. This is allowed at full and when count==1.
- Pointers increment and wrap from DEPTH-1 to 0.
- Head outputs come from storage at rptr (registered data, no combinational path from rom_data). Latency: a word fetched in cycle n appears at the head in cycle n+1 if the queue was empty.
- Branch has priority over push and pop. Pointers and count are cleared, pc <= branch_target, and no entry is pushed or popped that cycle.
  - Cycle after branch: out_valid=0, rom_addr=branch_target.
  - Two cycles after branch: out_valid=1 with out_pc=branch_target.
- A branch while empty or full behaves identically. A branch during reset is ignored.
- PC arithmetic is modulo 2^ADDR_W: 8'hFC + 4 = 8'h00, including in out_next_pc.
- count is never below 0 or above DEPTH. Any internal state that would violate this is a design error; the bench asserts on it.

Test Plan:
1. Reset then fill with R=1 for 2 edges, then R=0, LE=0, ROM[i]=i+0x100. Required: rom_addr steps 0,4,8,12. count reaches 4 after 4 cycles, full=1, rom_addr holds at 16. Head shows out_pc=0, out_instr=word at address 0, out_next_pc=4.
2. Steady flow with LE=1 continuously after reset. Required: out_valid rises one cycle after reset release. count stays at 1. out_pc sequence is 0,4,8,… with no gaps or repeats.
3. Full with simultaneous push/pop: fill to 4, then LE=1 for one cycle. Required: count stays 4, head advances to out_pc=4, the new tail is pc=16, and rom_addr becomes 20.
4. Branch flush: with count=3, assert branch=1, branch_target=0x40, LE=1. Required next cycle: count=0, out_valid=0, rom_addr=0x40. The cycle after: out_pc=0x40, out_next_pc=0x44, and entries 4/8 never appear.
5. PC wrap: branch to 0xF8 with LE=1. Required: the out_pc sequence is F8, FC, 00, 04, and out_next_pc at FC is 00.
6. Reset mid-operation: with count=2 and branch=1 in the same cycle, assert R=1. Required: count=0, rom_addr=0 (not the branch target), and all outputs are zero the next cycle.
